// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: song select, intro animation, play/pause/retry with lives, win/lose.
// Optional PAUSE_TIMEOUT_EN macro forces game over after PAUSE_TIMEOUT idle cycles in PAUSE.
module game_flow_ctrl #(
  parameter int unsigned                         NUM_SONGS     = 4,
  parameter int unsigned                         SONG_W        = 2,
  parameter int unsigned                         SPEED_W       = 3,
  parameter logic [NUM_SONGS*SPEED_W-1:0]        SPEED_TABLE   = {3'b010, 3'b100, 3'b101, 3'b101},
  parameter int unsigned                         DEFAULT_SONG  = 3,
  parameter int unsigned                         MAX_LIVES     = 3,
  parameter int unsigned                         LIVES_W       = 2,
  parameter int unsigned                         PAUSE_TIMEOUT = 100000000
) (
  input  logic               clk,
  input  logic               reset_out,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_up,
  input  logic               key_check,
  input  logic               failed,
  input  logic               song_done,
  input  logic               animate_finish,
  input  logic               in_animate_area,
  output logic [2:0]         state,
  output logic [SONG_W-1:0]  song,
  output logic [SPEED_W-1:0] speed,
  output logic               play_game,
  output logic               pause,
  output logic               menu_enabled,
  output logic               tips_display,
  output logic               animate_new_signal,
  output logic               animate_pixel_disabled,
  output logic [LIVES_W-1:0] lives,
  output logic               restart
);

  typedef enum logic [2:0] {
    StStart    = 3'd0,
    StPlaying  = 3'd1,
    StGameOver = 3'd2,
    StGameWon  = 3'd3,
    StPause    = 3'd4,
    StWait     = 3'd5,
    StAnimate  = 3'd6,
    StRetry    = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [SONG_W-1:0]  song_q, song_d;
  logic [LIVES_W-1:0] lives_q, lives_d;

  function automatic logic [SPEED_W-1:0] speed_of(input logic [SONG_W-1:0] s);
    return SPEED_TABLE[int'(s)*SPEED_W +: SPEED_W];
  endfunction

`ifdef PAUSE_TIMEOUT_EN
  localparam int unsigned CntW = (PAUSE_TIMEOUT > 1) ? $clog2(PAUSE_TIMEOUT) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
`else
  logic unused_pause_timeout;
  assign unused_pause_timeout = ^PAUSE_TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    lives_d = lives_q;
`ifdef PAUSE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StStart: begin
        // Confirm takes priority, so a simultaneous left/right never alters the song.
        if (key_check) begin
          state_d = StAnimate;
          lives_d = LIVES_W'(MAX_LIVES);
        end else if (key_left && !key_right) begin
          song_d = (song_q == SONG_W'(NUM_SONGS - 1)) ? '0 : song_q + 1'b1;
        end else if (key_right && !key_left) begin
          song_d = (song_q == '0) ? SONG_W'(NUM_SONGS - 1) : song_q - 1'b1;
        end
      end
      StAnimate: if (animate_finish) state_d = StWait;
      StWait:    if (key_check) state_d = StPlaying;
      StPlaying: begin
        if (failed) begin
          if (lives_q > LIVES_W'(1)) begin
            lives_d = lives_q - 1'b1;
            state_d = StRetry;
          end else begin
            lives_d = '0;
            state_d = StGameOver;
          end
        end else if (song_done) begin
          state_d = StGameWon;
        end else if (key_up) begin
          state_d = StPause;
`ifdef PAUSE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StPause: begin
        if (key_up || key_check) begin
          state_d = StPlaying;
`ifdef PAUSE_TIMEOUT_EN
        end else if (cnt_q == CntW'(PAUSE_TIMEOUT - 1)) begin
          state_d = StGameOver;
          lives_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StRetry: begin
        if (key_up) state_d = StGameOver;
        else if (key_check) state_d = StPlaying;
      end
      StGameOver: if (key_up) state_d = StStart;
      StGameWon:  if (key_up || key_check) state_d = StStart;
      default:    state_d = StStart;
    endcase
  end

  // Flags are decoded from next-state so they switch on the same edge as state.
  always_ff @(posedge clk or posedge reset_out) begin
    if (reset_out) begin
      state_q                <= StStart;
      song_q                 <= SONG_W'(DEFAULT_SONG);
      lives_q                <= LIVES_W'(MAX_LIVES);
      speed                  <= speed_of(SONG_W'(DEFAULT_SONG));
      play_game              <= 1'b0;
      pause                  <= 1'b0;
      menu_enabled           <= 1'b1;
      tips_display           <= 1'b0;
      animate_new_signal     <= 1'b0;
      animate_pixel_disabled <= 1'b0;
      restart                <= 1'b0;
`ifdef PAUSE_TIMEOUT_EN
      cnt_q                  <= '0;
`endif
    end else begin
      state_q                <= state_d;
      song_q                 <= song_d;
      lives_q                <= lives_d;
      speed                  <= (state_d == StPause || state_d == StRetry) ? '0
                                                                            : speed_of(song_d);
      play_game              <= (state_d == StPlaying) || (state_d == StPause) ||
                                (state_d == StRetry);
      pause                  <= (state_d == StPause) || (state_d == StRetry);
      menu_enabled           <= (state_d == StStart);
      tips_display           <= (state_d == StPause) || (state_d == StWait) ||
                                (state_d == StRetry);
      animate_new_signal     <= (state_d == StAnimate);
      animate_pixel_disabled <= (state_d == StAnimate) && !in_animate_area;
      restart                <= ((state_q == StGameOver) || (state_q == StGameWon)) &&
                                (state_d == StStart);
`ifdef PAUSE_TIMEOUT_EN
      cnt_q                  <= cnt_d;
`endif
    end
  end

  assign state = state_q;
  assign song  = song_q;
  assign lives = lives_q;

endmodule
